// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared FSM encoding, port IDs and size defaults for the memory arbiter
package mips_mem_pkg;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS} state_t;
    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_LDR  = 1'b1;
    localparam int   WORDS_DEF = 32;
    localparam int   DW_DEF    = 32;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the port not granted last wins a tie
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_port,
    output logic       o_any
);
    logic r_last;

    always_comb begin
        o_any  = |i_req;
        o_port = (&i_req) ? ~r_last : i_req[1];
    end

    // last grant starts on the loader so the CPU wins the first tie
    always_ff @(posedge clk) begin
        if (reset)
            r_last <= PORT_LDR;
        else if (i_en && o_any)
            r_last <= o_port;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between CPU and loader, zero-filling it after reset
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [31:0]   addr0,
    input  logic [31:0]   addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic [31:0]   ram_address,
    output logic [DW-1:0] ram_data_write,
    output logic          ram_write_en,
    output logic          ram_read_en,
    input  logic [DW-1:0] ram_data_out
);
    state_t        r_state, w_next;
    logic [31:0]   r_k, r_addr;
    logic [DW-1:0] r_wdata, r_rdata;
    logic          r_we, r_port, r_rvalid;
    logic          w_port, w_any, w_bad, w_init, w_acc, w_idle;

    assign w_init = r_state == S_INIT;
    assign w_acc  = r_state == S_ACCESS;
    assign w_idle = r_state == S_IDLE;
    assign w_bad  = (r_addr[1:0] != 2'b00) || (r_addr >= 32'(WORDS * 4));

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_req  ({req1, req0}),
        .i_en   (w_idle),
        .o_port (w_port),
        .o_any  (w_any)
    );

    // bad accesses still get their grant but never touch the RAM
    always_comb begin
        w_next         = w_init ? ((r_k == 32'(WORDS - 1)) ? S_IDLE : S_INIT)
                                : ((w_idle && w_any) ? S_ACCESS : S_IDLE);
        busy           = w_init;
        gnt0           = w_acc && (r_port == PORT_CPU);
        gnt1           = w_acc && (r_port == PORT_LDR);
        err            = w_acc && w_bad;
        ram_write_en   = w_init || (w_acc && r_we && !w_bad);
        ram_read_en    = w_acc && !r_we && !w_bad;
        ram_address    = w_init ? (r_k << 2) : r_addr;
        ram_data_write = w_init ? '0 : r_wdata;
        rvalid0        = r_rvalid && (r_port == PORT_CPU);
        rvalid1        = r_rvalid && (r_port == PORT_LDR);
        rdata          = r_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_INIT;
            r_k      <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_we     <= 1'b0;
            r_port   <= PORT_CPU;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_next;
            r_k      <= w_init ? r_k + 32'd1 : '0;
            r_rvalid <= ram_read_en;
            if (ram_read_en)
                r_rdata <= ram_data_out;
            if (w_idle && w_any) begin
                r_port  <= w_port;
                r_we    <= w_port ? we1 : we0;
                r_addr  <= w_port ? addr1 : addr0;
                r_wdata <= w_port ? wdata1 : wdata0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table, directed and random checks of mem_arbiter against a word-array model
module tb_mem_arbiter;
    localparam int WORDS = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0]   addr0 = 0, addr1 = 0;
    logic [DW-1:0] wdata0 = 0, wdata1 = 0;
    logic          gnt0, gnt1, rvalid0, rvalid1, err, busy, ram_write_en, ram_read_en;
    logic [DW-1:0] rdata, ram_data_write, ram_data_out;
    logic [31:0]   ram_address;

    logic [DW-1:0] ram [WORDS];
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] ref_rdata;
    int            n_checks = 0, n_err = 0;

    typedef struct {
        bit          p;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          e_err;
        bit          e_rv;
        logic [31:0] e_rd;
    } vec_t;
    vec_t vecs [11];

    always #5 clk = ~clk;

    mem_arbiter #(.WORDS(WORDS), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .err(err), .busy(busy), .ram_address(ram_address), .ram_data_write(ram_data_write),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en), .ram_data_out(ram_data_out)
    );

    assign ram_data_out = (ram_address < WORDS * 4) ? ram[ram_address[6:2]] : '0;
    always @(posedge clk)
        if (ram_write_en && ram_address < WORDS * 4)
            ram[ram_address[6:2]] <= ram_data_write;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        ref_rdata = '0;
    endtask

    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                         output bit e_err, output bit e_rv, output logic [31:0] e_rd);
        e_err = (a[1:0] != 2'b00) || (a >= WORDS * 4);
        e_rv  = !w && !e_err;
        if (e_rv) ref_rdata = ref_mem[a[6:2]];
        if (w && !e_err) ref_mem[a[6:2]] = d;
        e_rd = ref_rdata;
    endtask

    task automatic txn(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output bit o_err, output bit o_rv, output logic [31:0] o_rd);
        bit bad;
        int n;
        bad = (a[1:0] != 2'b00) || (a >= WORDS * 4);
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        n = 0;
        do begin tick; n++; end while (!(p ? gnt1 : gnt0) && n < 20);
        chk("gnt", p ? gnt1 : gnt0, 1);
        chk("gnt_other", p ? gnt0 : gnt1, 0);
        chk("ram_write_en", ram_write_en, w && !bad);
        chk("ram_read_en", ram_read_en, !w && !bad);
        if (!bad) chk("ram_address", ram_address, a);
        if (w && !bad) chk("ram_data_write", ram_data_write, d);
        o_err = err;
        req0 = 0;
        req1 = 0;
        tick;
        o_rv = p ? rvalid1 : rvalid0;
        chk("rvalid_other", p ? rvalid0 : rvalid1, 0);
        o_rd = rdata;
    endtask

    initial begin
        bit          o_err, o_rv, e_err, e_rv;
        logic [31:0] o_rd, e_rd, a;
        int          n, g;

        vecs[0]  = '{0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0};
        vecs[1]  = '{0, 0, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF};
        vecs[2]  = '{1, 0, 32'h13, 32'h0,        1, 0, 32'hDEADBEEF};
        vecs[3]  = '{1, 0, 32'h80, 32'h0,        1, 0, 32'hDEADBEEF};
        vecs[4]  = '{1, 1, 32'h7C, 32'h12345678, 0, 0, 32'hDEADBEEF};
        vecs[5]  = '{0, 0, 32'h7C, 32'h0,        0, 1, 32'h12345678};
        vecs[6]  = '{1, 0, 32'h00, 32'h0,        0, 1, 32'h0};
        vecs[7]  = '{0, 1, 32'h81, 32'h5A5A5A5A, 1, 0, 32'h0};
        vecs[8]  = '{1, 0, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF};
        vecs[9]  = '{0, 1, 32'h10, 32'h0,        0, 0, 32'hDEADBEEF};
        vecs[10] = '{0, 0, 32'h10, 32'h0,        0, 1, 32'h0};

        repeat (3) tick;
        chk("rst_busy", busy, 1);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_address", ram_address, 0);

        req0 = 1; we0 = 0; addr0 = 32'h10;
        reset = 0;
        for (int i = 0; i < WORDS; i++) begin
            chk("init_busy", busy, 1);
            chk("init_we", ram_write_en, 1);
            chk("init_addr", ram_address, i * 4);
            chk("init_data", ram_data_write, 0);
            chk("init_no_gnt", gnt0, 0);
            tick;
        end
        chk("init_done_busy", busy, 0);
        chk("idle_no_gnt", gnt0, 0);
        tick;
        chk("waited_gnt0", gnt0, 1);
        req0 = 0;
        tick;
        chk("waited_rvalid0", rvalid0, 1);
        chk("waited_rdata", rdata, 0);
        model_clear;

        foreach (vecs[i]) begin
            txn(vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].d, o_err, o_rv, o_rd);
            model(vecs[i].w, vecs[i].a, vecs[i].d, e_err, e_rv, e_rd);
            chk($sformatf("vec%0d_err", i), o_err, vecs[i].e_err);
            chk($sformatf("vec%0d_rvalid", i), o_rv, vecs[i].e_rv);
            chk($sformatf("vec%0d_rdata", i), o_rd, vecs[i].e_rd);
        end

        for (int i = 0; i < 80; i++) begin
            n = int'($urandom_range(0, 9));
            a = (n < 7) ? {25'd0, 5'($urandom_range(0, 31)), 2'b00}
              : (n == 7) ? {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))}
              : 32'd128 + 32'($urandom_range(0, 1000)) * 4;
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, o_err, o_rv, o_rd);
            model(dut.r_we, a, dut.r_wdata, e_err, e_rv, e_rd);
            chk("rnd_err", o_err, e_err);
            chk("rnd_rvalid", o_rv, e_rv);
            chk("rnd_rdata", o_rd, e_rd);
            if ($urandom_range(0, 3) == 0) begin
                tick;
                chk("rnd_idle_quiet", {gnt1, gnt0, rvalid1, rvalid0, err}, 0);
            end
        end

        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hCAFEF00D;
        tick;
        chk("abort_gnt0", gnt0, 1);
        reset = 1;
        req0 = 0;
        tick;
        chk("abort_quiet", {gnt1, gnt0, rvalid1, rvalid0, err}, 0);
        chk("abort_busy", busy, 1);
        chk("abort_addr0", ram_address, 0);
        reset = 0;
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        chk("reinit_len", n, 32);
        model_clear;

        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h10;
        g = 0;
        for (int c = 0; c < 40 && g < 8; c++) begin
            tick;
            if (rvalid0 || rvalid1) chk("alt_rdata", rdata, 0);
            if (gnt0 || gnt1) begin
                chk("alt_port", {gnt1, gnt0}, (g % 2) ? 2'b10 : 2'b01);
                g++;
            end
        end
        chk("alt_count", g, 8);
        req0 = 0;
        req1 = 0;
        tick;
        tick;

        txn(0, 0, 32'h10, 0, o_err, o_rv, o_rd);
        chk("after_abort_rvalid", o_rv, 1);
        chk("after_abort_rdata", o_rd, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
